// File: rtl/instr_encode.sv
// Instruction encoder: packs request fields into 32-bit words behind a
// one-deep valid/ready output stage, with load-32-bit-immediate expansion.
//
// state     | meaning
// S_IDLE    | output stage empty
// S_EMIT    | one encoded word held on out_word
// S_EMIT_HI | LO half of an li32 held, HI half waiting in hi_q
module instr_encode #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs,
    input  logic [3:0]        in_rt,
    input  logic [3:0]        in_cond,
    input  logic [31:0]       in_imm,
    input  logic [21:0]       in_md,
    input  logic              in_li32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              err_imm
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EMIT    = 2'd1,
        S_EMIT_HI = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_illegal_q, err_illegal_d;
    logic                err_imm_q, err_imm_d;

    logic [31:0]         enc_word;
    logic                enc_illegal;
    logic                enc_imm_ovf;
    logic [3:0]          b_field;
    logic [31:0]         lo_word;
    logic [31:0]         hi_word;
    logic                accept;
    logic                xfer;

    // The two li32 halves reuse the I-type opcodes 000101/000111.
    assign lo_word = {6'b000101, in_rd, 4'd0, 2'b00, in_imm[15:0]};
    assign hi_word = {6'b000111, in_rd, 4'd0, 2'b00, in_imm[31:16]};

    always_comb begin
        enc_word    = '0;
        enc_illegal = 1'b0;
        enc_imm_ovf = 1'b0;
        b_field     = (in_opcode == 6'b000101 || in_opcode == 6'b000111 ||
                       in_opcode == 6'b010101) ? 4'd0 : in_rs;
        if (!in_opcode[5]) begin
            if (in_opcode == 6'b010100) begin
                enc_word = {in_opcode, in_rd, in_rs, 18'd0};
            end else if (in_opcode[0]) begin
                enc_word    = {in_opcode, in_rd, b_field, in_imm[17:0]};
                enc_imm_ovf = |in_imm[31:18];
            end else begin
                enc_word = {in_opcode, in_rd, in_rs, in_rt, 14'd0};
            end
        end else begin
            case (in_opcode)
                6'b100000, 6'b100001, 6'b100010:
                    enc_word = {in_opcode, 4'd0, in_rs, in_rt, 14'd0};
                6'b100011: enc_word = {in_opcode, in_cond, in_md};
                6'b100100, 6'b100101:
                    enc_word = {in_opcode, in_rd, in_md};
                6'b100110: enc_word = {in_opcode, 4'd0, in_md};
                6'b100111: enc_word = {in_opcode, 26'd0};
                default:   enc_illegal = 1'b1;
            endcase
        end
        if (in_li32) begin
            enc_illegal = 1'b0;
            enc_imm_ovf = 1'b0;
        end
    end

    assign out_valid   = (state_q != S_IDLE);
    assign in_ready    = (state_q == S_IDLE) || ((state_q == S_EMIT) && out_ready);
    assign accept      = in_valid && in_ready;
    assign xfer        = out_valid && out_ready;
    assign out_word    = word_q;
    assign out_addr    = addr_q;
    assign err_illegal = err_illegal_q;
    assign err_imm     = err_imm_q;

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        hi_d          = hi_q;
        addr_d        = addr_q;
        err_illegal_d = 1'b0;
        err_imm_d     = 1'b0;

        if (xfer) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_EMIT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT_HI: begin
                if (out_ready) begin
                    word_d  = hi_q;
                    state_d = S_EMIT;
                end
            end
            default: state_d = state_q;
        endcase

        // Acceptance only happens in S_IDLE or in S_EMIT while the held word
        // leaves, so a new request always overrides the drain transition.
        if (accept) begin
            if (in_li32) begin
                word_d  = lo_word;
                hi_d    = hi_word;
                state_d = S_EMIT_HI;
            end else if (enc_illegal) begin
                err_illegal_d = 1'b1;
            end else begin
                word_d    = enc_word;
                state_d   = S_EMIT;
                err_imm_d = enc_imm_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            word_q        <= '0;
            hi_q          <= '0;
            addr_q        <= '0;
            err_illegal_q <= 1'b0;
            err_imm_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            hi_q          <= hi_d;
            addr_q        <= addr_d;
            err_illegal_q <= err_illegal_d;
            err_imm_q     <= err_imm_d;
        end
    end

endmodule
